mire_writer: RTL

- Wishbone classic write master that fills the SDRAM framebuffer with a test pattern (mire) on the sys_clk domain.
- The vga block reads the same framebuffer, so this block lets the display path be checked with no video stream present.
- It shares the SDRAM Wishbone slave with the vga reader through an arbiter. It releases the bus periodically so the reader is never starved.

---
 rtl/mire_writer_if.sv | 31 +++
 rtl/mire_writer.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/mire_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : mire_writer_if
//  Purpose  : Wishbone classic bus bundle between the mire writer (master)
//             and the shared SDRAM arbiter port (slave).
//  Revision : 1.0 - initial release
// ============================================================================
interface mire_writer_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [3:0]  sel;
    logic [2:0]  cti;
    logic [1:0]  bte;
    logic        ack;
    logic        err;
    logic        rty;

    modport master (
        output cyc, stb, we, adr, dat_ms, sel, cti, bte,
        input  ack, err, rty
    );

    modport slave (
        input  cyc, stb, we, adr, dat_ms, sel, cti, bte,
        output ack, err, rty
    );
endinterface
`default_nettype wire

// File: rtl/mire_writer.sv
`default_nettype none
// ============================================================================
//  Module   : mire_writer
//  Purpose  : Wishbone classic write master that paints a grid test pattern
//             into the framebuffer, frame after frame, releasing the bus
//             after every BURST writes so the display reader keeps its share.
//  Revision : 1.0 - initial release
// ============================================================================
module mire_writer #(
    parameter int          HDISP     = 800,
    parameter int          VDISP     = 480,
    parameter logic [31:0] BASE_ADDR = 32'h0,
    parameter int          BURST     = 64,
    parameter int          GRID      = 16
) (
    input  wire logic      sys_clk,
    input  wire logic      sys_rst,
    input  wire logic      en,
    mire_writer_if.master  wb,
    output logic           frame_done
);

    localparam int c_XW = (HDISP > 1) ? $clog2(HDISP) : 1;
    localparam int c_YW = (VDISP > 1) ? $clog2(VDISP) : 1;
    localparam int c_BW = (BURST > 1) ? $clog2(BURST) : 1;

    localparam logic [c_XW-1:0] c_X_LAST  = c_XW'(HDISP - 1);
    localparam logic [c_YW-1:0] c_Y_LAST  = c_YW'(VDISP - 1);
    localparam logic [c_XW-1:0] c_X_GMASK = c_XW'(GRID - 1);
    localparam logic [c_YW-1:0] c_Y_GMASK = c_YW'(GRID - 1);
    localparam logic [c_BW-1:0] c_B_LAST  = c_BW'(BURST - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd0;
    localparam logic [1:0] c_ST_WRITE   = 2'd1;
    localparam logic [1:0] c_ST_RELEASE = 2'd2;

    logic [1:0]      r_state;
    logic [c_XW-1:0] r_x;
    logic [c_YW-1:0] r_y;
    logic [31:0]     r_lin;      // running y*HDISP + x, avoids a multiplier
    logic [c_BW-1:0] r_burst;
    logic            r_cyc;
    logic            r_stb;
    logic            r_we;
    logic [3:0]      r_sel;
    logic [31:0]     r_adr;
    logic [31:0]     r_dat;
    logic            r_frame_done;

    logic            w_x_last;
    logic            w_y_last;
    logic            w_frame_end;
    logic [c_XW-1:0] w_x_nxt;
    logic [c_YW-1:0] w_y_nxt;
    logic [31:0]     w_lin_nxt;
    logic [31:0]     w_adr_cur;
    logic [31:0]     w_adr_nxt;
    logic [31:0]     w_dat_cur;
    logic [31:0]     w_dat_nxt;
    logic            w_done;

    // White grid lines every GRID pixels plus a one-pixel border on the far edges.
    function automatic logic [23:0] f_pixel(input logic [c_XW-1:0] px,
                                            input logic [c_YW-1:0] py);
        logic white;
        white = ((px & c_X_GMASK) == '0) || ((py & c_Y_GMASK) == '0) ||
                (px == c_X_LAST) || (py == c_Y_LAST);
        return white ? 24'hFFFFFF : 24'h000000;
    endfunction

    // Next raster position and the request words for current and next pixel.
    always_comb begin
        w_x_last    = (r_x == c_X_LAST);
        w_y_last    = (r_y == c_Y_LAST);
        w_frame_end = w_x_last && w_y_last;
        w_x_nxt     = w_x_last ? '0 : r_x + 1'b1;
        w_y_nxt     = r_y;
        if (w_x_last) begin
            w_y_nxt = w_y_last ? '0 : r_y + 1'b1;
        end
        w_lin_nxt   = w_frame_end ? 32'd0 : r_lin + 32'd1;
        w_adr_cur   = BASE_ADDR + (r_lin << 2);
        w_adr_nxt   = BASE_ADDR + (w_lin_nxt << 2);
        w_dat_cur   = {8'h00, f_pixel(r_x, r_y)};
        w_dat_nxt   = {8'h00, f_pixel(w_x_nxt, w_y_nxt)};
        w_done      = wb.ack || wb.err;     // err completes the transfer, pixel lost
    end

    // Bus FSM: issue writes, advance raster on completion, release periodically.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state      <= c_ST_IDLE;
            r_x          <= '0;
            r_y          <= '0;
            r_lin        <= '0;
            r_burst      <= '0;
            r_cyc        <= 1'b0;
            r_stb        <= 1'b0;
            r_we         <= 1'b0;
            r_sel        <= 4'h0;
            r_adr        <= 32'h0;
            r_dat        <= 32'h0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                c_ST_IDLE: begin
                    if (en) begin
                        r_state <= c_ST_WRITE;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_we    <= 1'b1;
                        r_sel   <= 4'hF;
                        r_adr   <= w_adr_cur;
                        r_dat   <= w_dat_cur;
                    end
                end
                c_ST_WRITE: begin
                    if (!r_stb) begin
                        // one-cycle gap after rty is over: re-issue same request
                        r_stb <= 1'b1;
                    end else if (w_done) begin
                        r_x          <= w_x_nxt;
                        r_y          <= w_y_nxt;
                        r_lin        <= w_lin_nxt;
                        r_frame_done <= w_frame_end;
                        if ((r_burst == c_B_LAST) || !en) begin
                            r_state <= c_ST_RELEASE;
                            r_burst <= '0;
                            r_cyc   <= 1'b0;
                            r_stb   <= 1'b0;
                            r_we    <= 1'b0;
                            r_sel   <= 4'h0;
                            r_adr   <= 32'h0;
                            r_dat   <= 32'h0;
                        end else begin
                            r_burst <= r_burst + 1'b1;
                            r_adr   <= w_adr_nxt;
                            r_dat   <= w_dat_nxt;
                        end
                    end else if (wb.rty) begin
                        r_stb <= 1'b0;
                    end
                end
                c_ST_RELEASE: begin
                    if (en) begin
                        r_state <= c_ST_WRITE;
                        r_cyc   <= 1'b1;
                        r_stb   <= 1'b1;
                        r_we    <= 1'b1;
                        r_sel   <= 4'hF;
                        r_adr   <= w_adr_cur;
                        r_dat   <= w_dat_cur;
                    end else begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign wb.cyc     = r_cyc;
    assign wb.stb     = r_stb;
    assign wb.we      = r_we;
    assign wb.sel     = r_sel;
    assign wb.adr     = r_adr;
    assign wb.dat_ms  = r_dat;
    assign wb.cti     = 3'b000;
    assign wb.bte     = 2'b00;
    assign frame_done = r_frame_done;

endmodule
`default_nettype wire
